icache_line_fill: RTL and testbench
===================================

Name: icache_line_fill

Overview:
- Miss-fill engine directly upstream of the instruction-cache 16x256 data array.
- Accepts one line-miss request from the icache controller and issues one burst read to the backing memory.
- Assembles four 64-bit beats into a 256-bit line, writes the whole line into the data array with all byte-enables set, then signals completion so the controller can replay the lookup.

Parameters:
- ADDR_WIDTH, 32, byte address width
- BEAT_WIDTH, 64, memory beat width in bits
- LINE_WIDTH, 256, cache line width in bits
- NUM_BEATS, LINE_WIDTH/BEAT_WIDTH = 4, beats per line
- SET_BITS, 4, data-array index width
- OFFSET_BITS, 5, log2(LINE_WIDTH/8)

Ports:
- clk  in  1  clock; single clock domain
- rst_n  in  1  synchronous, active-low reset
- miss_valid  in  1  controller requests a fill
- miss_addr  in  ADDR_WIDTH  missing byte address
- miss_ready  out  1  engine idle, request accepted this cycle
- bmem_addr  out  ADDR_WIDTH  line-aligned burst address
- bmem_read  out  1  burst read request
- bmem_ready  in  1  memory accepted the request
- bmem_rvalid  in  1  read beat valid
- bmem_rdata  in  BEAT_WIDTH  read beat data
- data_csb  out  1  data array chip select, active low
- data_web  out  1  data array write enable, active low
- data_wmask  out  LINE_WIDTH/8  byte write mask
- data_addr  out  SET_BITS  data array index
- data_din  out  LINE_WIDTH  line to write
- fill_done  out  1  one-cycle pulse: line committed in the array
- fill_addr  out  ADDR_WIDTH  line-aligned address of the completed fill
- fill_line  out  LINE_WIDTH  filled line, for critical-word bypass

Behaviour:
- States: IDLE, REQ, RECV, WRITE, COMMIT, DONE. Reset (rst_n=0 at a clk edge) forces IDLE, beat counter 0, line buffer 0, latched address 0.
- Reset values while in IDLE: miss_ready=1, bmem_read=0, bmem_addr=0, data_csb=1, data_web=1, data_wmask=0, data_addr=0, data_din=0, fill_done=0, fill_addr=0, fill_line=0.
- IDLE: miss_ready=1.
  - On miss_valid, latch line_addr = {miss_addr[ADDR_WIDTH-1:OFFSET_BITS], 0} and go to REQ.
  - miss_ready=0 in every other state; miss_valid outside IDLE is ignored.
- REQ: bmem_read=1 and bmem_addr=line_addr, held stable until bmem_ready. bmem_ready=1 -> RECV.
  - bmem_rvalid in the same cycle as bmem_ready is not captured; memory starts beats no earlier than the next cycle.
- RECV: each cycle with bmem_rvalid=1 stores bmem_rdata into line bits [64*cnt+63 : 64*cnt] and increments cnt (2 bits).
  - Beat 0 is the lowest address.
  - On the beat with cnt==NUM_BEATS-1, cnt wraps to 0 and the state goes to WRITE.
  - Gaps (bmem_rvalid=0) are allowed and hold cnt.
- bmem_rvalid in IDLE, REQ, WRITE, COMMIT or DONE is ignored and must not corrupt the buffer.
- WRITE (1 cycle): data_csb=0, data_web=0, data_wmask all ones, data_addr=line_addr[OFFSET_BITS+SET_BITS-1:OFFSET_BITS], data_din=line buffer.
  - The array registers its inputs at this edge and commits memory at the following edge.
- COMMIT (1 cycle): data_csb=1, data_web=1. The array write lands at the end of this cycle.
- DONE (1 cycle): fill_done=1, fill_addr=line_addr, fill_line=line buffer, then IDLE.
  - fill_addr and fill_line hold their values after DONE until the next DONE.
  - Fill latency from miss acceptance to fill_done = 1 (REQ min) + bmem handshake wait + beat cycles + 3.
- A new miss can be accepted in the cycle after fill_done; there are no back-to-back overlapping fills.
- Reset mid-fill (any state): abandon the fill, no array write, data_csb=1 on the next cycle; beats still arriving afterwards are ignored in IDLE.
- Outside WRITE, data_csb=1 and data_web=1 always, so the data array never sees a spurious write.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles mid-RECV after 2 beats -> miss_ready=1, data_csb=1, no write; next fill of same set writes fresh data only.
- Basic fill: miss_addr=0x0000_1234, bmem_ready on 1st REQ cycle, 4 back-to-back beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> bmem_addr=0x0000_1220, data_addr=1, data_wmask=0xFFFF_FFFF, data_din={0x44..,0x33..,0x22..,0x11..}, fill_done exactly 3 cycles after last beat; array readback at index 1 matches.
- Stalled handshake: bmem_ready low 5 cycles -> bmem_read and bmem_addr stable throughout, miss_ready=0, later miss_valid pulses ignored.
- Gapped beats: rvalid pattern 1,0,0,1,0,1,1 plus rvalid asserted in the bmem_ready cycle -> beats placed in order, stray beat not captured, single write.
- Index wrap: miss_addr=0x0000_01E0 (set 15) then 0x0000_0200 (set 0) -> data_addr 15 then 0; fill_addr 0x1E0 then 0x200.
- Back-to-back misses: miss_valid held high across fill_done -> second request accepted the cycle after fill_done; no write overlaps the first fill.

Source files
------------

// File: rtl/icache_line_fill.sv
// icache_line_fill: miss-fill engine for the instruction-cache data array.
// Accepts one line-miss request, issues one burst read, assembles NUM_BEATS
// beats into one line, writes it into the data array with all byte-enables
// set, then pulses fill_done so the controller can replay the lookup.
//
// Ports:
//   clk, rst_n                    clock; synchronous active-low reset
//   miss_valid/miss_addr/miss_ready  miss request from the icache controller
//   bmem_addr/bmem_read/bmem_ready   burst read request to backing memory
//   bmem_rvalid/bmem_rdata           read beats, lowest address first
//   data_csb/data_web/data_wmask/data_addr/data_din  data array write port
//   fill_done/fill_addr/fill_line    completion pulse, line address and line
module icache_line_fill #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned BEAT_WIDTH  = 64,
  parameter int unsigned LINE_WIDTH  = 256,
  parameter int unsigned NUM_BEATS   = LINE_WIDTH / BEAT_WIDTH,
  parameter int unsigned SET_BITS    = 4,
  parameter int unsigned OFFSET_BITS = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    miss_valid,
  input  logic [ADDR_WIDTH-1:0]   miss_addr,
  output logic                    miss_ready,
  output logic [ADDR_WIDTH-1:0]   bmem_addr,
  output logic                    bmem_read,
  input  logic                    bmem_ready,
  input  logic                    bmem_rvalid,
  input  logic [BEAT_WIDTH-1:0]   bmem_rdata,
  output logic                    data_csb,
  output logic                    data_web,
  output logic [LINE_WIDTH/8-1:0] data_wmask,
  output logic [SET_BITS-1:0]     data_addr,
  output logic [LINE_WIDTH-1:0]   data_din,
  output logic                    fill_done,
  output logic [ADDR_WIDTH-1:0]   fill_addr,
  output logic [LINE_WIDTH-1:0]   fill_line
);

  localparam int unsigned CntBits = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [ADDR_WIDTH-1:0] OffsetMask =
      ADDR_WIDTH'((64'd1 << OFFSET_BITS) - 64'd1);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StRecv,
    StWrite,
    StCommit,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [CntBits-1:0]    cnt_q, cnt_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] fill_addr_q, fill_addr_d;
  logic [LINE_WIDTH-1:0] fill_line_q, fill_line_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      line_q      <= '0;
      addr_q      <= '0;
      fill_addr_q <= '0;
      fill_line_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      line_q      <= line_d;
      addr_q      <= addr_d;
      fill_addr_q <= fill_addr_d;
      fill_line_q <= fill_line_d;
    end
  end

  // Next-state logic. Beats are only captured in StRecv, so rvalid arriving
  // alongside bmem_ready or after the last beat never touches the buffer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_d      = line_q;
    addr_d      = addr_q;
    fill_addr_d = fill_addr_q;
    fill_line_d = fill_line_q;
    unique case (state_q)
      StIdle: begin
        if (miss_valid) begin
          addr_d  = miss_addr & ~OffsetMask;
          state_d = StReq;
        end
      end
      StReq: begin
        if (bmem_ready) begin
          state_d = StRecv;
        end
      end
      StRecv: begin
        if (bmem_rvalid) begin
          for (int unsigned b = 0; b < NUM_BEATS; b++) begin
            if (cnt_q == CntBits'(b)) begin
              line_d[b*BEAT_WIDTH +: BEAT_WIDTH] = bmem_rdata;
            end
          end
          if (cnt_q == CntBits'(NUM_BEATS - 1)) begin
            cnt_d   = '0;
            state_d = StWrite;
          end else begin
            cnt_d = cnt_q + CntBits'(1);
          end
        end
      end
      StWrite: begin
        state_d = StCommit;
      end
      StCommit: begin
        // Load the completion registers so they are valid throughout StDone
        // and keep their value until the next fill completes.
        fill_addr_d = addr_q;
        fill_line_d = line_q;
        state_d     = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from state only; the array port is idle (csb/web
  // high, everything else zero) outside the single write cycle.
  always_comb begin
    miss_ready = (state_q == StIdle);
    bmem_read  = (state_q == StReq);
    bmem_addr  = '0;
    data_csb   = 1'b1;
    data_web   = 1'b1;
    data_wmask = '0;
    data_addr  = '0;
    data_din   = '0;
    fill_done  = (state_q == StDone);
    if (state_q == StReq) begin
      bmem_addr = addr_q;
    end
    if (state_q == StWrite) begin
      data_csb   = 1'b0;
      data_web   = 1'b0;
      data_wmask = '1;
      data_addr  = addr_q[OFFSET_BITS +: SET_BITS];
      data_din   = line_q;
    end
  end

  assign fill_addr = fill_addr_q;
  assign fill_line = fill_line_q;

endmodule

// File: tb/tb_icache_line_fill.sv
// Self-checking bench for icache_line_fill: directed and randomized fills
// checked against expected lines, set indices and a behavioural data array.
module tb_icache_line_fill;

  logic         clk;
  logic         rst_n;
  logic         miss_valid;
  logic [31:0]  miss_addr;
  logic         miss_ready;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_ready;
  logic         bmem_rvalid;
  logic [63:0]  bmem_rdata;
  logic         data_csb;
  logic         data_web;
  logic [31:0]  data_wmask;
  logic [3:0]   data_addr;
  logic [255:0] data_din;
  logic         fill_done;
  logic [31:0]  fill_addr;
  logic [255:0] fill_line;

  icache_line_fill dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .miss_valid (miss_valid),
    .miss_addr  (miss_addr),
    .miss_ready (miss_ready),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_ready (bmem_ready),
    .bmem_rvalid(bmem_rvalid),
    .bmem_rdata (bmem_rdata),
    .data_csb   (data_csb),
    .data_web   (data_web),
    .data_wmask (data_wmask),
    .data_addr  (data_addr),
    .data_din   (data_din),
    .fill_done  (fill_done),
    .fill_addr  (fill_addr),
    .fill_line  (fill_line)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  int wr_count;

  logic [63:0]  beats [4];
  logic [255:0] golden [16];
  logic [255:0] mem_model [16];

  // Behavioural data array: inputs registered on the write edge, memory
  // updated on the following edge, byte mask honoured.
  bit           pend;
  logic [3:0]   pa;
  logic [255:0] pd;
  logic [31:0]  pm;
  always @(posedge clk) begin
    if (!data_csb && !data_web) begin
      pend     <= 1'b1;
      pa       <= data_addr;
      pd       <= data_din;
      pm       <= data_wmask;
      wr_count <= wr_count + 1;
    end else begin
      pend <= 1'b0;
    end
    if (pend) begin
      for (int b = 0; b < 32; b++) begin
        if (pm[b]) mem_model[pa][8*b +: 8] <= pd[8*b +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rand_beats();
    for (int b = 0; b < 4; b++) beats[b] = {$urandom, $urandom};
  endtask

  // Starts and ends at a negedge with the DUT idle. pat gives rvalid per
  // receive cycle (all ones past bit 31); stray drives rvalid with junk in the
  // bmem_ready cycle; hold keeps miss_valid high with next_a across fill_done.
  task automatic do_fill(input logic [31:0] a, input int rdy_wait, input logic [31:0] pat,
                         input bit stray, input bit hold, input logic [31:0] next_a);
    logic [31:0]  la;
    logic [3:0]   set;
    logic [255:0] line;
    int           k;
    int           i;
    int           wr0;
    la   = a & 32'hFFFF_FFE0;
    set  = la[8:5];
    line = {beats[3], beats[2], beats[1], beats[0]};
    wr0  = wr_count;
    check("idle_ready", miss_ready, 1);
    miss_valid = 1'b1;
    miss_addr  = a;
    @(negedge clk);
    for (i = 0; i <= rdy_wait; i++) begin
      check("req_read", bmem_read, 1);
      check("req_addr", bmem_addr, la);
      check("req_busy", miss_ready, 0);
      check("req_csb", data_csb, 1);
      bmem_ready  = (i == rdy_wait);
      bmem_rvalid = (i == rdy_wait) ? stray : 1'($urandom_range(0, 1));
      bmem_rdata  = {$urandom, $urandom};
      miss_valid  = 1'($urandom_range(0, 1));
      miss_addr   = $urandom;
      @(negedge clk);
    end
    bmem_ready = 1'b0;
    k = 0;
    i = 0;
    while (k < 4) begin
      check("recv_busy", miss_ready, 0);
      check("recv_no_done", fill_done, 0);
      check("recv_csb", data_csb, 1);
      bmem_rvalid = (i >= 32) ? 1'b1 : pat[i];
      if (bmem_rvalid) begin
        bmem_rdata = beats[k];
        k++;
      end else begin
        bmem_rdata = {$urandom, $urandom};
      end
      miss_valid = 1'($urandom_range(0, 1));
      i++;
      @(negedge clk);
    end
    // Write cycle: stray beats keep arriving and must be ignored.
    miss_valid  = 1'b0;
    bmem_rvalid = 1'b1;
    bmem_rdata  = {$urandom, $urandom};
    check("wr_csb", data_csb, 0);
    check("wr_web", data_web, 0);
    check("wr_mask", data_wmask, 32'hFFFF_FFFF);
    check("wr_addr", data_addr, set);
    check("wr_din", data_din, line);
    check("wr_no_done", fill_done, 0);
    @(negedge clk);
    check("commit_csb", data_csb, 1);
    check("commit_web", data_web, 1);
    check("commit_no_done", fill_done, 0);
    bmem_rdata = {$urandom, $urandom};
    if (hold) begin
      miss_valid = 1'b1;
      miss_addr  = next_a;
    end
    @(negedge clk);
    golden[set] = line;
    check("done_pulse", fill_done, 1);
    check("done_addr", fill_addr, la);
    check("done_line", fill_line, line);
    check("done_busy", miss_ready, 0);
    check("one_write", wr_count - wr0, 1);
    check("array_readback", mem_model[set], golden[set]);
    @(negedge clk);
    bmem_rvalid = 1'b0;
    check("done_one_cycle", fill_done, 0);
    check("hold_addr", fill_addr, la);
    check("hold_line", fill_line, line);
    check("back_idle", miss_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] next_a;
    bit          prev_hold;
    bit          hold;
    int          wr0;
    for (int s = 0; s < 16; s++) golden[s] = '0;
    rst_n       = 1'b0;
    miss_valid  = 1'b0;
    miss_addr   = '0;
    bmem_ready  = 1'b0;
    bmem_rvalid = 1'b0;
    bmem_rdata  = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", miss_ready, 1);
    check("rst_read", bmem_read, 0);
    check("rst_baddr", bmem_addr, 0);
    check("rst_csb", data_csb, 1);
    check("rst_web", data_web, 1);
    check("rst_mask", data_wmask, 0);
    check("rst_daddr", data_addr, 0);
    check("rst_din", data_din, 0);
    check("rst_done", fill_done, 0);
    check("rst_faddr", fill_addr, 0);
    check("rst_fline", fill_line, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic fill with back-to-back beats.
    beats[0] = 64'h1111_1111_1111_1111;
    beats[1] = 64'h2222_2222_2222_2222;
    beats[2] = 64'h3333_3333_3333_3333;
    beats[3] = 64'h4444_4444_4444_4444;
    do_fill(32'h0000_1234, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    @(negedge clk);

    // Handshake stalled for 5 cycles.
    rand_beats();
    do_fill(32'h0000_5678, 5, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);

    // Gapped beats 1,0,0,1,0,1,1 with a stray beat in the bmem_ready cycle.
    rand_beats();
    do_fill(32'h0000_9AC0, 0, 32'h0000_0069, 1'b1, 1'b0, 32'h0);

    // Set index wrap 15 -> 0, back to back with miss_valid held.
    rand_beats();
    do_fill(32'h0000_01E0, 1, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_0200);
    rand_beats();
    do_fill(32'h0000_0200, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    @(negedge clk);

    // Reset after two beats: fill abandoned, no write.
    wr0        = wr_count;
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_3420;
    @(negedge clk);
    miss_valid  = 1'b0;
    bmem_ready  = 1'b1;
    @(negedge clk);
    bmem_ready  = 1'b0;
    bmem_rvalid = 1'b1;
    bmem_rdata  = {$urandom, $urandom};
    @(negedge clk);
    bmem_rdata  = {$urandom, $urandom};
    @(negedge clk);
    rst_n      = 1'b0;
    bmem_rdata = {$urandom, $urandom};
    @(negedge clk);
    check("midrst_ready", miss_ready, 1);
    check("midrst_csb", data_csb, 1);
    check("midrst_read", bmem_read, 0);
    check("midrst_done", fill_done, 0);
    @(negedge clk);
    rst_n      = 1'b1;
    bmem_rdata = {$urandom, $urandom};
    @(negedge clk);
    bmem_rvalid = 1'b0;
    check("midrst_ready2", miss_ready, 1);
    check("midrst_nowrite", wr_count - wr0, 0);
    check("midrst_array", mem_model[1], golden[1]);
    rand_beats();
    do_fill(32'h0000_3420, 2, $urandom, 1'b1, 1'b0, 32'h0);

    // Randomized fills.
    prev_hold = 1'b0;
    next_a    = '0;
    for (int n = 0; n < 40; n++) begin
      a      = prev_hold ? next_a : $urandom;
      hold   = (n == 39) ? 1'b0 : 1'($urandom_range(0, 1));
      next_a = $urandom;
      rand_beats();
      do_fill(a, int'($urandom_range(0, 6)), $urandom, 1'($urandom_range(0, 1)), hold, next_a);
      if (!hold) begin
        miss_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      prev_hold = hold;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
